// File: rtl/led_output_ctrl.sv
// LED output controller: debounced "next" button cycles through four pattern
// sources, blanks the LEDs after each switch, and applies 8-step PWM dimming.
module led_output_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLANK_CYCLES    = 10000000,
  parameter int unsigned PWM_DIV         = 1250
) (
  input  logic        clock_100mhz,
  input  logic        reset_n,
  input  logic [15:0] led_A,
  input  logic [15:0] led_B,
  input  logic [15:0] led_C,
  input  logic [15:0] led_D,
  input  logic        btn_next,
  input  logic [2:0]  brightness,
  output logic [15:0] led,
  output logic [1:0]  mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLANK_CYCLES + 1);
  localparam int PW_W = $clog2(PWM_DIV + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWM_DIV - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
  localparam logic [PW_W-1:0] PW_ONE  = PW_W'(1);

  typedef enum logic {SHOW, BLANK} state_e;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      mode_q, mode_d;
  state_e          state_q, state_d;
  logic [BL_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [PW_W-1:0] presc_q, presc_d;
  logic [2:0]      phase_q, phase_d;
  logic [15:0]     led_q, led_d;
  logic            next_pulse;
  logic            pwm_on;
  logic [15:0]     sel_pattern;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sync1_d     = btn_next;
    sync2_d     = sync1_q;
    db_d        = db_q;
    db_cnt_d    = '0;
    mode_d      = mode_q;
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    presc_d     = presc_q + PW_ONE;
    phase_d     = phase_q;
    next_pulse  = 1'b0;

    // The stability counter only runs while the synchronized level disagrees.
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end

    next_pulse = db_d & ~db_q;
    mode_d     = mode_q + {1'b0, next_pulse};

    case (state_q)
      SHOW: begin
        if (next_pulse) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
        end
      end
      BLANK: begin
        // A press during blanking restarts the full interval.
        if (next_pulse) begin
          blank_cnt_d = '0;
        end else if (blank_cnt_q == BL_LAST) begin
          state_d = SHOW;
        end else begin
          blank_cnt_d = blank_cnt_q + BL_ONE;
        end
      end
      default: state_d = SHOW;
    endcase

    if (presc_q == PW_LAST) begin
      presc_d = '0;
      phase_d = phase_q + 3'd1;
    end
  end

  always_comb begin
    pwm_on = (phase_q <= brightness);
    case (mode_q)
      2'd0:    sel_pattern = led_A;
      2'd1:    sel_pattern = led_B;
      2'd2:    sel_pattern = led_C;
      default: sel_pattern = led_D;
    endcase
    led_d = (state_q == SHOW && pwm_on) ? sel_pattern : 16'h0000;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_cnt_q    <= '0;
      mode_q      <= 2'd0;
      state_q     <= SHOW;
      blank_cnt_q <= '0;
      presc_q     <= '0;
      phase_q     <= 3'd0;
      led_q       <= 16'h0000;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_output_ctrl.sv
// Bench for led_output_ctrl: cycle-by-cycle comparison against a behavioural
// model under random stimulus, plus directed scenarios with literal expectations.
module tb_led_output_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int DIV = 1;
  localparam int BLK_LONG = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] led_a, led_b, led_c, led_d;
  logic        btn;
  logic [2:0]  brightness;
  logic [15:0] led, led_long;
  logic [1:0]  mode, mode_long;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_output_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLANK_CYCLES(BLK), .PWM_DIV(DIV)) u_dut (
    .clock_100mhz(clk), .reset_n(reset_n),
    .led_A(led_a), .led_B(led_b), .led_C(led_c), .led_D(led_d),
    .btn_next(btn), .brightness(brightness), .led(led), .mode(mode)
  );

  // Longer blanking so a second press can land inside the blank interval.
  led_output_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLANK_CYCLES(BLK_LONG), .PWM_DIV(DIV)) u_dut_long (
    .clock_100mhz(clk), .reset_n(reset_n),
    .led_A(led_a), .led_B(led_b), .led_C(led_c), .led_D(led_d),
    .btn_next(btn), .brightness(brightness), .led(led_long), .mode(mode_long)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button level seen two edges late, a level flips once the
  // last DEB synchronized samples all disagree, blanking lasts BLK edges after
  // the most recent press, PWM phase is the edge count divided down.
  bit          m_s1, m_s2, m_db;
  bit          m_hist[$];
  int          m_mode, m_blank, m_n;
  logic [15:0] m_led;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0;
    m_hist.delete();
    m_mode = 0; m_blank = 0; m_n = 0;
    m_led = 16'h0000;
  endtask

  task automatic model_step();
    logic [15:0] pats [4];
    int  phase;
    bit  flip, pulse;
    pats[0] = led_a; pats[1] = led_b; pats[2] = led_c; pats[3] = led_d;
    phase = (m_n / DIV) % 8;
    m_led = (m_blank == 0 && phase <= int'(brightness)) ? pats[m_mode] : 16'h0000;
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    flip = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] == m_db) flip = 0;
    pulse = 0;
    if (flip) begin
      pulse = m_s2;
      m_db  = m_s2;
    end
    m_blank = pulse ? BLK : (m_blank > 0 ? m_blank - 1 : 0);
    m_mode  = (m_mode + int'(pulse)) % 4;
    m_s2 = m_s1;
    m_s1 = btn;
    m_n++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      model_step();
      #1;
      check("model_led", 32'(led), 32'(m_led));
      check("model_mode", 32'(mode), 32'(m_mode));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    btn     = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_window(input int n, input bit use_long, output int zeros, output int changes);
    logic [1:0] prev;
    prev = use_long ? mode_long : mode;
    zeros = 0;
    changes = 0;
    repeat (n) begin
      @(negedge clk);
      if ((use_long ? led_long : led) == 16'h0000) zeros++;
      if ((use_long ? mode_long : mode) != prev) changes++;
      prev = use_long ? mode_long : mode;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int z, c, z2, c2, run_left;
    int exp_seq [4];
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0;

    reset_n = 1'b0;
    btn = 1'b0;
    brightness = 3'd7;
    led_a = 16'h8195; led_b = 16'h3C5A; led_c = 16'h0F0F; led_d = 16'hA001;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_mode", 32'(mode), 32'h0);

    // Pattern A visible from the second edge after release.
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("first_led", 32'(led), 32'h8195);
    check("first_mode", 32'(mode), 32'h0);

    // One long press: one mode step, exactly 8 blank cycles, then pattern B.
    do_reset();
    btn = 1'b1;
    run_window(10, 0, z, c);
    btn = 1'b0;
    run_window(30, 0, z2, c2);
    check("press_blank_cycles", 32'(z + z2), 32'd8);
    check("press_mode_changes", 32'(c + c2), 32'd1);
    check("press_mode", 32'(mode), 32'd1);
    check("press_led_b", 32'(led), 32'h3C5A);

    // Bounce shorter than the debounce time is ignored.
    do_reset();
    z2 = 0; c2 = 0;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      run_window(2, 0, z, c);
      z2 += z; c2 += c;
    end
    btn = 1'b0;
    run_window(20, 0, z, c);
    check("bounce_blank_cycles", 32'(z + z2), 32'd0);
    check("bounce_mode_changes", 32'(c + c2), 32'd0);
    check("bounce_mode", 32'(mode), 32'd0);

    // Four clean presses walk the mode through a full wrap.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      btn = 1'b1;
      repeat (8) @(negedge clk);
      btn = 1'b0;
      repeat (22) @(negedge clk);
      check("press_seq_mode", 32'(mode), 32'(exp_seq[p]));
    end

    // Second press inside the long blank restarts it: 10 + 16 blank cycles.
    do_reset();
    btn = 1'b1;
    run_window(6, 1, z, c);
    btn = 1'b0;
    run_window(4, 1, z2, c2);
    z += z2; c += c2;
    btn = 1'b1;
    run_window(8, 1, z2, c2);
    z += z2; c += c2;
    btn = 1'b0;
    run_window(40, 1, z2, c2);
    check("extend_blank_cycles", 32'(z + z2), 32'd26);
    check("extend_mode", 32'(mode_long), 32'd2);

    // PWM duty: 1 of 8 at brightness 0, 4 of 8 at brightness 3.
    do_reset();
    led_a = 16'hFFFF;
    brightness = 3'd0;
    repeat (4) @(negedge clk);
    run_window(16, 0, z, c);
    check("duty_b0_on", 32'(16 - z), 32'd2);
    brightness = 3'd3;
    repeat (8) @(negedge clk);
    run_window(16, 0, z, c);
    check("duty_b3_on", 32'(16 - z), 32'd8);

    // Asynchronous reset in the middle of a blank.
    brightness = 3'd7;
    led_a = 16'h8195;
    do_reset();
    btn = 1'b1;
    repeat (8) @(negedge clk);
    btn = 1'b0;
    check("pre_reset_mode", 32'(mode), 32'd1);
    check("pre_reset_led", 32'(led), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_mode", 32'(mode), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_led", 32'(led), 32'h8195);

    // Random soak against the model, including a mid-run reset.
    do_reset();
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (run_left == 0) begin
        btn = ~btn;
        run_left = $urandom_range(1, 14);
      end
      run_left--;
      if ($urandom_range(0, 49) == 0) brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: led_a = 16'($urandom);
          1: led_b = 16'($urandom);
          2: led_c = 16'($urandom);
          default: led_d = 16'($urandom);
        endcase
      end
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_output_ctrl.md
LED_OUTPUT_CTRL -- requirements
Module: led_output_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable clock cycles that qualify a button level (10 ms at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 10000000, is the length of the post-switch blanking interval in clock cycles (100 ms).
REQ-003 Parameter PWM_DIV, default 1250, is the number of clock cycles per PWM phase step (8 steps per 10 kHz PWM period).
REQ-004 clock_100mhz  input  1  system clock; the only clock in the block.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 led_A, led_B, led_C, led_D  input  16 each  pattern buses from the pattern generators, asynchronous to any internal phase.
REQ-007 btn_next  input  1  raw pushbutton, asynchronous and bouncy, active-high.
REQ-008 brightness  input  3  PWM duty select; duty = (brightness+1)/8.
REQ-009 led  output  16  board LED drive.
REQ-010 mode  output  2  current source: 0=A, 1=B, 2=C, 3=D.

Function
REQ-011 btn_next SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL update its debounced level to the synchronized level only after that level has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where the synchronized level equals the debounced level clears the stability counter.
REQ-013 A 0->1 transition of the debounced level SHALL produce exactly one single-cycle next pulse; a 1->0 transition produces none.
REQ-014 On a next pulse, mode SHALL advance by one, modulo 4 (3 wraps to 0), registered on the same edge that registers the pulse.
REQ-015 The control FSM SHALL have exactly two states, SHOW and BLANK.
  - SHOW -> BLANK on a next pulse, with the blank counter loaded to 0.
  - BLANK -> SHOW when the blank counter reaches BLANK_CYCLES-1.
REQ-016 A next pulse while in BLANK SHALL advance mode and restart the blank counter from 0, so the full blanking interval follows the last press.
REQ-017 The PWM prescaler SHALL count 0..PWM_DIV-1 and wrap; the 3-bit PWM phase SHALL increment on each prescaler wrap and wrap from 7 to 0.
REQ-018 pwm_on SHALL be 1 exactly when the PWM phase is <= brightness.
  - brightness=7 gives constant on; brightness=0 gives 1/8 duty.
REQ-019 The selected pattern SHALL be led_A, led_B, led_C or led_D as indexed by mode.
REQ-020 led SHALL be registered: led <= (state==SHOW && pwm_on) ? selected pattern : 16'h0000.
  - Latency from a pattern input change to led is 1 cycle.
REQ-021 A brightness change SHALL take effect on the next PWM phase comparison, with no phase reset.
REQ-022 All counters SHALL be sized to hold their parameter maximum without overflow; no counter wraps other than as specified.

Reset
REQ-023 While reset_n is low, asynchronously: led=16'h0000, mode=0, state=SHOW, debounced level=0, synchronizer flops=0, and all counters and the PWM phase=0.
REQ-024 After reset_n deasserts, the first active edge SHALL be the first normal cycle; a button already held high at reset release SHALL generate a next pulse only after debouncing (REQ-012).
REQ-025 Reset asserted mid-blank or mid-debounce SHALL abort that operation immediately, with no pulse or mode change generated.

Verification (DEBOUNCE_CYCLES=4, BLANK_CYCLES=8, PWM_DIV=1)
REQ-026 Reset, brightness=7, led_A=16'h8195 -> led=16'h8195 from the 2nd edge after release, mode=0.
REQ-027 btn_next held high for 10 cycles -> mode 0->1 once; led=0 for exactly 8 cycles, then equals led_B.
REQ-028 btn_next toggling every 2 cycles for 20 cycles, then low -> no mode change, led never blanks.
REQ-029 Four clean presses spaced 30 cycles apart -> mode sequence 1,2,3,0 (wrap verified).
  - A second press inside a blank extends the blank to 8 cycles after the second pulse.
REQ-030 brightness=0 with a constant pattern -> led nonzero exactly 1 cycle in every 8; brightness=3 -> 4 cycles in every 8.
REQ-031 reset_n pulsed low during BLANK -> led=0 and mode=0 immediately (asynchronous); SHOW with led_A on the cycle after release.
